// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package prog_loader_pkg;

  localparam int unsigned CHAIN_LEN_DEF = 552;
  localparam int unsigned WORD_W_DEF    = 32;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Bitstream word stream between the configuration source (master) and the loader (slave).
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) ();

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/prog_crc16.sv
// Serial CRC-16, one bit per enabled cycle, MSB-first update; clr reloads the seed.
module prog_crc16
  import prog_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb_c;
  assign fb_c = crc[15] ^ din;

  always_ff @(posedge prog_clk) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb_c ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serializes bitstream words LSB-first onto a row programming chain for CHAIN_LEN bits.
// Optional readback CRC over chain_dout is built when PROG_READBACK_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF
) (
  input  logic                           prog_clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  prog_loader_if.slave                   s,
  output logic                           chain_din,
  output logic                           chain_en,
  input  logic                           chain_dout,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt,
  output logic [15:0]                    readback_crc
);

  localparam int unsigned NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int unsigned BIDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WIDX_W    = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned BCNT_W    = $clog2(CHAIN_LEN + 1);

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NW - 1);
  localparam logic [BIDX_W-1:0] WORD_END  = BIDX_W'(WORD_W - 1);
  localparam logic [BIDX_W-1:0] FINAL_END = BIDX_W'(LAST_BITS - 1);

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [BIDX_W-1:0] bit_idx;
  logic [WIDX_W-1:0] word_idx;
  logic              s_ready_q;

  logic hs_c, last_bit_c, final_bit_c, start_ok_c;

  assign s.s_ready   = s_ready_q;
  assign hs_c        = s.s_valid & s_ready_q;
  assign last_bit_c  = (bit_idx == ((word_idx == LAST_WORD) ? FINAL_END : WORD_END));
  assign final_bit_c = last_bit_c && (word_idx == LAST_WORD);
  assign start_ok_c  = (state == ST_IDLE) && start && !abort;

  // Ready is offered while the last bit of a non-final word is on the chain.
  function automatic logic ready_for(input logic [WIDX_W-1:0] w, input logic [BIDX_W-1:0] b);
    return (b == WORD_END) && (w != LAST_WORD);
  endfunction

  always_ff @(posedge prog_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      word_idx  <= '0;
      s_ready_q <= 1'b0;
      chain_din <= 1'b0;
      chain_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (chain_en) bit_cnt <= bit_cnt + BCNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (start_ok_c) begin
            state     <= ST_LOAD;
            s_ready_q <= 1'b1;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            word_idx  <= '0;
          end
        end

        ST_LOAD: begin
          if (abort) begin
            state     <= ST_IDLE;
            s_ready_q <= 1'b0;
            busy      <= 1'b0;
          end else if (s.s_valid) begin
            state     <= ST_SHIFT;
            chain_en  <= 1'b1;
            chain_din <= s.s_data[0];
            shreg     <= WORD_W'(s.s_data >> 1);
            bit_idx   <= '0;
            s_ready_q <= ready_for(word_idx, '0);
          end
        end

        ST_SHIFT: begin
          if (abort) begin
            state     <= ST_IDLE;
            chain_en  <= 1'b0;
            s_ready_q <= 1'b0;
            busy      <= 1'b0;
          end else if (final_bit_c) begin
            state     <= ST_DONE;
            chain_en  <= 1'b0;
            s_ready_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (last_bit_c) begin
            word_idx <= word_idx + WIDX_W'(1);
            bit_idx  <= '0;
            if (hs_c) begin
              chain_din <= s.s_data[0];
              shreg     <= WORD_W'(s.s_data >> 1);
              s_ready_q <= ready_for(word_idx + WIDX_W'(1), '0);
            end else begin
              // No word waiting: park in LOAD with the chain frozen.
              state     <= ST_LOAD;
              chain_en  <= 1'b0;
              s_ready_q <= 1'b1;
            end
          end else begin
            bit_idx   <= bit_idx + BIDX_W'(1);
            chain_din <= shreg[0];
            shreg     <= shreg >> 1;
            s_ready_q <= ready_for(word_idx, bit_idx + BIDX_W'(1));
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PROG_READBACK_EN
  prog_crc16 u_crc (
    .prog_clk (prog_clk),
    .rst      (rst),
    .clr      (start_ok_c),
    .en       (chain_en),
    .din      (chain_dout),
    .crc      (readback_crc)
  );
`else
  logic unused_chain_dout;
  assign unused_chain_dout = chain_dout;
  assign readback_crc      = 16'h0000;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected chain bits plus a fabric shift-chain model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned CHAIN_LEN = CHAIN_LEN_DEF;
  localparam int unsigned WORD_W    = WORD_W_DEF;
  localparam int unsigned NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int unsigned BCNT_W    = $clog2(CHAIN_LEN + 1);

  logic              prog_clk = 1'b0;
  logic              rst, start, abort;
  logic              chain_din, chain_en, chain_dout, busy, done;
  logic [BCNT_W-1:0] bit_cnt;
  logic [15:0]       readback_crc;

  prog_loader_if #(.WORD_W(WORD_W)) sif ();

  prog_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk     (prog_clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .s            (sif.slave),
    .chain_din    (chain_din),
    .chain_en     (chain_en),
    .chain_dout   (chain_dout),
    .busy         (busy),
    .done         (done),
    .bit_cnt      (bit_cnt),
    .readback_crc (readback_crc)
  );

  always #5 prog_clk = ~prog_clk;

  // Fabric row: shifts chain_din in on enabled edges, oldest content emerges on chain_dout.
  logic [CHAIN_LEN-1:0] fab;
  logic                 fab_fill;
  assign chain_dout = fab[CHAIN_LEN-1];
  always @(posedge prog_clk) begin
    if (fab_fill) fab <= '1;
    else if (chain_en) fab <= {fab[CHAIN_LEN-2:0], chain_din};
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [68:0]          pat;
  logic [CHAIN_LEN-1:0] stream;
  bit                   exp_q[$];

  int                   r_hs, r_en, r_done, r_maxrun, r_gap, r_gap_bc, r_bc_bad, r_done_bc;
  logic                 r_done_busy;
  logic [15:0]          r_crc, r_crc_hold;
  logic [CHAIN_LEN-1:0] r_cap;

  function automatic logic [WORD_W-1:0] get_word(input int w);
    logic [WORD_W-1:0] v;
    if (w < int'(NW) - 1) begin
      v = stream[w*WORD_W +: WORD_W];
    end else begin
      v = WORD_W'(32'hC3A5_96FF);
      v[LAST_BITS-1:0] = stream[(NW-1)*WORD_W +: LAST_BITS];
    end
    return v;
  endfunction

  function automatic logic [15:0] crc_ref(input logic [CHAIN_LEN-1:0] bits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < int'(CHAIN_LEN); i++) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // One complete load; stimulus pushes expected bits on each handshake, chain_en pops them.
  task automatic run_load(input int stall_word, input int stall_len, input int abort_bit, input int start_bit);
    int w, run, stall_cnt, post;
    bit fin, aborted, restarted, stalling, eb;
    logic [WORD_W-1:0] wd;
    exp_q.delete();
    r_hs = 0; r_en = 0; r_done = 0; r_maxrun = 0; r_gap = 0; r_gap_bc = -1; r_bc_bad = 0;
    r_done_bc = -1; r_done_busy = 1'bx; r_crc = 'x; r_crc_hold = 'x; r_cap = '0;
    w = 0; run = 0; stall_cnt = 0; post = 0; fin = 0; aborted = 0; restarted = 0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (abort) begin
        abort = 1'b0;
        aborted = 1;
        exp_q.delete();
        n_cmp++;
        if (chain_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sif.s_ready !== 1'b0) begin
          n_err++;
          $display("FAIL abort_response: en=%0b busy=%0b done=%0b ready=%0b, required all 0",
                   chain_en, busy, done, sif.s_ready);
        end
      end
      if (bit_cnt !== BCNT_W'(r_en)) r_bc_bad++;
      if (chain_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL chain_bit[%0d]: got %0b, required no shift", r_en, chain_din);
        end else begin
          eb = exp_q.pop_front();
          if (chain_din !== eb) begin
            n_err++;
            $display("FAIL chain_bit[%0d]: got %0b, required %0b", r_en, chain_din, eb);
          end
        end
        if (r_en < int'(CHAIN_LEN)) r_cap[r_en] = chain_din;
        r_en++;
        run++;
        if (run > r_maxrun) r_maxrun = run;
      end else begin
        run = 0;
        if (r_en > 0 && r_done == 0 && !done && !aborted) begin
          if (r_gap == 0) r_gap_bc = int'(bit_cnt);
          r_gap++;
        end
      end
      if (done) begin
        r_done++;
        r_crc = readback_crc;
        r_done_bc = int'(bit_cnt);
        r_done_busy = busy;
      end else if (r_done > 0 && !aborted) begin
        r_crc_hold = readback_crc;
        fin = 1;
        n_cmp++;
        if (busy !== 1'b0 || sif.s_ready !== 1'b0 || chain_en !== 1'b0) begin
          n_err++;
          $display("FAIL after_done: busy=%0b ready=%0b en=%0b, required 000", busy, sif.s_ready, chain_en);
        end
      end
      if (aborted) begin
        post++;
        if (post >= 30) fin = 1;
      end
      start = 1'b0;
      if (!fin && !aborted) begin
        if (abort_bit >= 0 && r_en == abort_bit && chain_en) abort = 1'b1;
        if (start_bit >= 0 && r_en == start_bit && chain_en && !restarted) begin
          start = 1'b1;
          restarted = 1;
        end
        stalling = (w == stall_word) && sif.s_ready && (stall_cnt < stall_len);
        if (w < int'(NW) && !stalling) begin
          wd = get_word(w);
          sif.s_valid = 1'b1;
          sif.s_data  = wd;
        end else begin
          sif.s_valid = 1'b0;
          if (stalling) stall_cnt++;
        end
        if (sif.s_valid && sif.s_ready && !abort) begin
          for (int i = 0; i < ((w == int'(NW) - 1) ? int'(LAST_BITS) : int'(WORD_W)); i++)
            exp_q.push_back(wd[i]);
          w++;
          r_hs++;
        end
      end else begin
        sif.s_valid = 1'b0;
      end
      @(negedge prog_clk);
    end
    if (!fin) begin
      n_cmp++;
      n_err++;
      $display("FAIL load_timeout: bits=%0d done=%0d, required completion", r_en, r_done);
    end
    sif.s_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; fab_fill = 1'b1;
    sif.s_valid = 1'b0; sif.s_data = '0;
    repeat (3) @(negedge prog_clk);
    n_cmp++; if (sif.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %0b, required 0", sif.s_ready); end
    n_cmp++; if (chain_din !== 1'b0) begin n_err++; $display("FAIL rst_chain_din: got %0b, required 0", chain_din); end
    n_cmp++; if (chain_en !== 1'b0) begin n_err++; $display("FAIL rst_chain_en: got %0b, required 0", chain_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b, required 0", done); end
    n_cmp++; if (bit_cnt !== '0) begin n_err++; $display("FAIL rst_bit_cnt: got %0d, required 0", bit_cnt); end
    n_cmp++; if (readback_crc !== 16'h0) begin n_err++; $display("FAIL rst_crc: got %h, required 0000", readback_crc); end
    rst = 1'b0; fab_fill = 1'b0;
    @(negedge prog_clk);
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || sif.s_ready !== 1'b0) begin
      n_err++; $display("FAIL start_with_abort: busy=%0b ready=%0b, required 00", busy, sif.s_ready);
    end
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_cmp++;
      if (busy !== 1'b1 || sif.s_ready !== 1'b1 || chain_en !== 1'b0) begin
        n_err++; $display("FAIL wait_for_word: busy=%0b ready=%0b en=%0b, required 110", busy, sif.s_ready, chain_en);
      end
      @(negedge prog_clk);
    end
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || sif.s_ready !== 1'b0) begin
      n_err++; $display("FAIL abort_in_load: busy=%0b ready=%0b, required 00", busy, sif.s_ready);
    end
  endtask

  task automatic check_complete(input string tag);
    n_cmp++; if (r_cap !== stream) begin n_err++; $display("FAIL %s_bits: captured %h, required %h", tag, r_cap, stream); end
    n_cmp++; if (r_en != int'(CHAIN_LEN)) begin n_err++; $display("FAIL %s_en_cycles: got %0d, required %0d", tag, r_en, CHAIN_LEN); end
    n_cmp++; if (r_hs != int'(NW)) begin n_err++; $display("FAIL %s_handshakes: got %0d, required %0d", tag, r_hs, NW); end
    n_cmp++; if (r_done != 1) begin n_err++; $display("FAIL %s_done_pulses: got %0d, required 1", tag, r_done); end
    n_cmp++; if (r_done_bc != int'(CHAIN_LEN)) begin n_err++; $display("FAIL %s_done_bit_cnt: got %0d, required %0d", tag, r_done_bc, CHAIN_LEN); end
    n_cmp++; if (r_done_busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_at_done: got %0b, required 0", tag, r_done_busy); end
    n_cmp++; if (r_bc_bad != 0) begin n_err++; $display("FAIL %s_bit_cnt_track: %0d bad cycles, required 0", tag, r_bc_bad); end
  endtask

  task automatic test_full_load();
    run_load(-1, 0, -1, -1);
    check_complete("full");
    n_cmp++; if (r_maxrun != int'(CHAIN_LEN)) begin n_err++; $display("FAIL full_en_run: got %0d, required %0d", r_maxrun, CHAIN_LEN); end
    n_cmp++; if (r_gap != 0) begin n_err++; $display("FAIL full_gap: got %0d, required 0", r_gap); end
  endtask

  task automatic test_stall();
    run_load(3, 5, -1, -1);
    check_complete("stall");
    n_cmp++; if (r_gap != 5) begin n_err++; $display("FAIL stall_gap: got %0d, required 5", r_gap); end
    n_cmp++; if (r_gap_bc != 96) begin n_err++; $display("FAIL stall_bit_cnt: got %0d, required 96", r_gap_bc); end
  endtask

  task automatic test_abort();
    run_load(-1, 0, 10 * 32 + 5, -1);
    n_cmp++; if (r_done != 0) begin n_err++; $display("FAIL abort_done: got %0d pulses, required 0", r_done); end
    n_cmp++; if (r_en != 325) begin n_err++; $display("FAIL abort_bits: got %0d, required 325", r_en); end
    n_cmp++; if (r_bc_bad != 0) begin n_err++; $display("FAIL abort_bit_cnt_track: %0d bad cycles, required 0", r_bc_bad); end
    run_load(-1, 0, -1, -1);
    check_complete("reload");
  endtask

  task automatic test_start_ignored();
    run_load(-1, 0, -1, 200);
    check_complete("start_in_shift");
  endtask

  task automatic test_rst_mid();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data  = WORD_W'(32'hA5A5_0F0F);
    for (int c = 0; c < 200 && bit_cnt < BCNT_W'(40); c++) @(negedge prog_clk);
    n_cmp++;
    if (chain_en !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_pre: en=%0b busy=%0b, required 11", chain_en, busy);
    end
    rst = 1'b1;
    @(negedge prog_clk);
    n_cmp++;
    if (chain_en !== 1'b0 || chain_din !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        sif.s_ready !== 1'b0 || bit_cnt !== '0 || readback_crc !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mid: en=%0b din=%0b busy=%0b done=%0b ready=%0b cnt=%0d crc=%h, required all 0",
               chain_en, chain_din, busy, done, sif.s_ready, bit_cnt, readback_crc);
    end
    rst = 1'b0;
    sif.s_valid = 1'b0;
    @(negedge prog_clk);
  endtask

  task automatic test_back_to_back();
    logic [CHAIN_LEN-1:0] ones;
    logic [15:0] exp1, exp2;
    ones = '1;
`ifdef PROG_READBACK_EN
    exp1 = crc_ref(ones);
    exp2 = crc_ref(stream);
`else
    exp1 = 16'h0;
    exp2 = 16'h0;
`endif
    fab_fill = 1'b1;
    @(negedge prog_clk);
    fab_fill = 1'b0;
    run_load(-1, 0, -1, -1);
    check_complete("readback1");
    n_cmp++; if (r_crc !== exp1) begin n_err++; $display("FAIL readback1_crc: got %h, required %h", r_crc, exp1); end
    n_cmp++; if (r_crc_hold !== exp1) begin n_err++; $display("FAIL readback1_hold: got %h, required %h", r_crc_hold, exp1); end
    run_load(-1, 0, -1, -1);
    check_complete("readback2");
    n_cmp++; if (r_crc !== exp2) begin n_err++; $display("FAIL readback2_crc: got %h, required %h", r_crc, exp2); end
  endtask

  initial begin
    pat    = 69'h1F_9E37_79B9_7F4A_7C15;
    stream = {8{pat}};
    test_reset();
    test_full_load();
    test_stall();
    test_abort();
    test_start_ignored();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
